// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter with a start/busy/done handshake.
// It shifts one binary bit per clock and updates bcd_out/ovf only on completion.
module bin2bcd_serial #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   adj;

    // Add-3 correction: every nibble is adjusted from its pre-adjust value.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    carry_d   = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_d   = shift_q << 1;
                scratch_d = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
                // A digit pushed past the top nibble means the value needs more digits.
                carry_d   = carry_q | adj[BCD_W-1];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scratch_d;
                    ovf_d   = carry_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bcd_out = bcd_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Bench for bin2bcd_serial: a 4-digit and a 3-digit instance checked against
// an arithmetic decimal-digit model (divide/modulo by powers of ten).
module tb_bin2bcd_serial;

    logic        clk;
    logic        reset;
    logic        start4, start3;
    logic [11:0] bin_in;
    logic [15:0] bcd4;
    logic        busy4, done4, ovf4;
    logic [11:0] bcd3;
    logic        busy3, done3, ovf3;

    int n_checks;
    int n_fail;

    bin2bcd_serial #(.BIN_W(12), .DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .bin_in(bin_in),
        .bcd_out(bcd4), .busy(busy4), .done(done4), .ovf(ovf4)
    );

    bin2bcd_serial #(.BIN_W(12), .DIGITS(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .bin_in(bin_in),
        .bcd_out(bcd3), .busy(busy3), .done(done3), .ovf(ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Decimal digits of v (low 'digits' digits), packed one per nibble.
    function automatic logic [15:0] model_bcd(input int v, input int digits);
        logic [15:0] r = '0;
        for (int i = 0; i < digits; i++) begin
            r = r | (16'((v / pow10(i)) % 10) << (4 * i));
        end
        return r;
    endfunction

    function automatic logic model_ovf(input int v, input int digits);
        return v >= pow10(digits);
    endfunction

    function automatic logic [15:0] cur_bcd(input bit sel);
        return sel ? {4'h0, bcd3} : bcd4;
    endfunction

    // Present v with start for one accepting edge; returns #1 after that edge.
    task automatic start_conv(input logic [11:0] v, input bit sel);
        @(negedge clk);
        bin_in = v;
        if (sel) start3 = 1'b1; else start4 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        start4 = 1'b0;
    endtask

    // Run one conversion; lat = edges from accept to done, busy_cyc = busy samples.
    task automatic convert(input logic [11:0] v, input bit sel,
                           output int lat, output int busy_cyc, output bit got);
        lat = 0;
        busy_cyc = 0;
        got = 1'b0;
        start_conv(v, sel);
        if (sel ? busy3 : busy4) busy_cyc++;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (sel ? done3 : done4) begin
                got = 1'b1;
                break;
            end
            if (sel ? busy3 : busy4) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start4 = 1'b0;
        start3 = 1'b0;
        bin_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy4, done4, ovf4, bcd4} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_state4: got busy=%b done=%b ovf=%b bcd=%h, want all 0", busy4, done4, ovf4, bcd4);
        end
        n_checks++;
        if ({busy3, done3, ovf3, bcd3} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_state3: got busy=%b done=%b ovf=%b bcd=%h, want all 0", busy3, done3, ovf3, bcd3);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero();
        int lat, bc;
        bit got;
        convert(12'd0, 1'b0, lat, bc, got);
        n_checks++;
        if (!got || lat != 12) begin
            n_fail++;
            $display("FAIL zero_latency: got done=%b after %0d edges, want 12", got, lat);
        end
        n_checks++;
        if (bcd4 !== 16'h0000 || ovf4 !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_result: got bcd=%h ovf=%b busy=%b, want 0000 0 0", bcd4, ovf4, busy4);
        end
        n_checks++;
        if (bc != 12) begin
            n_fail++;
            $display("FAIL zero_busy_cycles: got %0d, want 12", bc);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done4 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done_width: done=%b one cycle after pulse, want 0", done4);
        end
    endtask

    task automatic test_values();
        int vals[3] = '{4095, 1234, 9};
        int lat, bc;
        bit got;
        foreach (vals[i]) begin
            convert(12'(vals[i]), 1'b0, lat, bc, got);
            n_checks++;
            if (!got || lat != 12 || bcd4 !== model_bcd(vals[i], 4) || ovf4 !== 1'b0) begin
                n_fail++;
                $display("FAIL value_%0d: got done=%b lat=%0d bcd=%h ovf=%b, want lat=12 bcd=%h ovf=0",
                         vals[i], got, lat, bcd4, ovf4, model_bcd(vals[i], 4));
            end
        end
    endtask

    task automatic test_random();
        int v, lat, bc;
        bit got;
        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 4095));
            convert(12'(v), 1'b0, lat, bc, got);
            n_checks++;
            if (!got || lat != 12 || bcd4 !== model_bcd(v, 4) || ovf4 !== model_ovf(v, 4)) begin
                n_fail++;
                $display("FAIL random_%0d: got done=%b lat=%0d bcd=%h ovf=%b, want lat=12 bcd=%h ovf=%b",
                         v, got, lat, bcd4, ovf4, model_bcd(v, 4), model_ovf(v, 4));
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int done_k = -1;
        logic [15:0] res = '0;
        start_conv(12'd100, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 5) begin
                start4 = 1'b1;
                bin_in = 12'd777;
            end
            if (k == 6) start4 = 1'b0;
            if (k == 8) bin_in = 12'($urandom_range(0, 4095));
            @(posedge clk);
            #1;
            if (done4) begin
                ndone++;
                if (done_k < 0) begin
                    done_k = k;
                    res = bcd4;
                end
            end
        end
        n_checks++;
        if (ndone != 1 || done_k != 12) begin
            n_fail++;
            $display("FAIL ignore_start_done: got %0d pulses first at edge %0d, want 1 at edge 12", ndone, done_k);
        end
        n_checks++;
        if (res !== 16'h0100) begin
            n_fail++;
            $display("FAIL ignore_start_value: got bcd=%h, want 0100", res);
        end
    endtask

    task automatic test_back_to_back();
        int e = 0;
        int last_e = 0;
        int n = 0;
        logic [15:0] last_bcd;
        @(negedge clk);
        bin_in = 12'd0;
        start4 = 1'b1;
        last_bcd = bcd4;
        while (n < 5 && e < 200) begin
            @(posedge clk);
            #1;
            if (done4) begin
                n_checks++;
                if (bcd4 !== model_bcd(n, 4) || (e - last_e) != (n == 0 ? 12 : 13)) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got bcd=%h gap=%0d, want bcd=%h gap=%0d",
                             n, bcd4, e - last_e, model_bcd(n, 4), (n == 0 ? 12 : 13));
                end
                last_e = e;
                last_bcd = bcd4;
                n++;
                bin_in = 12'(n);
                if (n == 5) start4 = 1'b0;
            end else begin
                n_checks++;
                if (bcd4 !== last_bcd) begin
                    n_fail++;
                    $display("FAIL b2b_stable: bcd changed to %h without done, want %h", bcd4, last_bcd);
                end
            end
            e++;
        end
        start4 = 1'b0;
        n_checks++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results, want 5", n);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc, nd;
        bit got;
        start_conv(12'd999, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy4, done4, ovf4, bcd4} !== 19'h0) begin
            n_fail++;
            $display("FAIL abort_async: got busy=%b done=%b ovf=%b bcd=%h, want all 0", busy4, done4, ovf4, bcd4);
        end
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done4 || busy4) nd++;
        end
        n_checks++;
        if (nd != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d cycles with done/busy, want 0", nd);
        end
        convert(12'd58, 1'b0, lat, bc, got);
        n_checks++;
        if (!got || lat != 12 || bcd4 !== 16'h0058 || ovf4 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_next: got done=%b lat=%0d bcd=%h ovf=%b, want lat=12 bcd=0058 ovf=0", got, lat, bcd4, ovf4);
        end
    endtask

    task automatic test_overflow();
        int vals[3] = '{1000, 999, 4095};
        int v, lat, bc;
        bit got;
        for (int i = 0; i < 13; i++) begin
            v = (i < 3) ? vals[i] : int'($urandom_range(0, 4095));
            convert(12'(v), 1'b1, lat, bc, got);
            n_checks++;
            if (!got || lat != 12 || cur_bcd(1'b1) !== model_bcd(v, 3) || ovf3 !== model_ovf(v, 3)) begin
                n_fail++;
                $display("FAIL ovf3_%0d: got done=%b lat=%0d bcd=%h ovf=%b, want lat=12 bcd=%h ovf=%b",
                         v, got, lat, bcd3, ovf3, model_bcd(v, 3), model_ovf(v, 3));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        start4 = 1'b0;
        start3 = 1'b0;
        bin_in = '0;
        test_reset();
        test_zero();
        test_values();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
